// File: rtl/bsg_manycore_link_sif_edge_absorber.sv
// ---------------------------------------------------------------------------
// bsg_manycore_link_sif_edge_absorber: registered edge tie-off that credits stray forward packets
// and absorbs stray return packets.  Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bsg_manycore_link_sif_edge_absorber #(
  parameter int addr_width_p   = 32,
  parameter int data_width_p   = 32,
  parameter int x_cord_width_p = -1,
  parameter int y_cord_width_p = -1,
  parameter int fifo_els_p     = 2,
  parameter int count_width_p  = 16,
  // return packet = {pkt_type[2], data, reg_id[5], y_cord, x_cord}
  localparam int ret_w_lp      = 2 + data_width_p + 5 + y_cord_width_p + x_cord_width_p,
  // forward packet = {addr, payload, return_pkt}
  localparam int fwd_pkt_w_lp  = addr_width_p + data_width_p + ret_w_lp,
  // link_sif = {fwd{v, data, ready_and_rev}, rev{v, data, ready_and_rev}}
  localparam int link_sif_w_lp = (fwd_pkt_w_lp + 2) + (ret_w_lp + 2)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [link_sif_w_lp-1:0] link_sif_i,
  output logic [link_sif_w_lp-1:0] link_sif_o,
  output logic [count_width_p-1:0] fwd_count_o,
  output logic [count_width_p-1:0] rev_drop_count_o,
  output logic                     err_o,
  output logic [ret_w_lp-1:0]      first_ret_pkt_o
);

  localparam int ptr_w_lp = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
  localparam int occ_w_lp = $clog2(fifo_els_p + 1);

  typedef struct packed {
    logic [addr_width_p-1:0] addr;
    logic [data_width_p-1:0] payload;
    logic [ret_w_lp-1:0]     return_pkt;
  } fwd_pkt_s;

  typedef struct packed {
    logic     v;
    fwd_pkt_s data;
    logic     ready_and_rev;
  } fwd_sif_s;

  typedef struct packed {
    logic                v;
    logic [ret_w_lp-1:0] data;
    logic                ready_and_rev;
  } rev_sif_s;

  typedef struct packed {
    fwd_sif_s fwd;
    rev_sif_s rev;
  } link_sif_s;

  link_sif_s w_in, w_out;
  assign w_in       = link_sif_i;
  assign link_sif_o = w_out;

  logic [ret_w_lp-1:0] r_mem [fifo_els_p];
  logic [ptr_w_lp-1:0] r_rptr, r_wptr;
  logic [occ_w_lp-1:0] r_occ;

  logic w_full, w_empty, w_fwd_ready, w_rev_v, w_accept, w_deq;

  // Ready comes only from registered occupancy, never from the array's rev ready.
  assign w_full      = (r_occ == occ_w_lp'(fifo_els_p));
  assign w_empty     = (r_occ == '0);
  assign w_fwd_ready = ~w_full & ~reset_i;
  assign w_rev_v     = ~w_empty & ~reset_i;
  assign w_accept    = w_in.fwd.v & w_fwd_ready;
  assign w_deq       = w_rev_v & w_in.rev.ready_and_rev;

  always_comb begin
    w_out                   = '0;
    w_out.fwd.ready_and_rev = w_fwd_ready;
    w_out.rev.v             = w_rev_v;
    w_out.rev.data          = r_mem[r_rptr];
    w_out.rev.ready_and_rev = ~reset_i;
  end

  function automatic logic [ptr_w_lp-1:0] next_ptr(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(fifo_els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (w_accept) r_mem[r_wptr] <= w_in.fwd.data.return_pkt;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_rptr <= '0;
      r_wptr <= '0;
      r_occ  <= '0;
    end else begin
      if (w_accept) r_wptr <= next_ptr(r_wptr);
      if (w_deq)    r_rptr <= next_ptr(r_rptr);
      if (w_accept & ~w_deq)      r_occ <= r_occ + 1'b1;
      else if (~w_accept & w_deq) r_occ <= r_occ - 1'b1;
    end
  end

  // Event counters saturate at all-ones; error capture latches only the first accept.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      fwd_count_o      <= '0;
      rev_drop_count_o <= '0;
      err_o            <= 1'b0;
      first_ret_pkt_o  <= '0;
    end else begin
      if (w_accept && (fwd_count_o != '1))       fwd_count_o      <= fwd_count_o + 1'b1;
      if (w_in.rev.v && (rev_drop_count_o != '1)) rev_drop_count_o <= rev_drop_count_o + 1'b1;
      if (w_accept && !err_o) begin
        err_o           <= 1'b1;
        first_ret_pkt_o <= w_in.fwd.data.return_pkt;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bsg_manycore_link_sif_edge_absorber.sv
// Randomized scoreboard bench for bsg_manycore_link_sif_edge_absorber.
`default_nettype none

module tb_bsg_manycore_link_sif_edge_absorber;

  localparam int AW   = 8;
  localparam int DW   = 16;
  localparam int XW   = 3;
  localparam int YW   = 2;
  localparam int ELS  = 3;
  localparam int CW   = 3;
  localparam int RW   = 2 + DW + 5 + YW + XW;
  localparam int FPW  = AW + DW + RW;
  localparam int REVW = RW + 2;
  localparam int LW   = (FPW + 2) + REVW;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_i;
  logic [LW-1:0] link_sif_i, link_sif_o;
  logic [CW-1:0] fwd_count_o, rev_drop_count_o;
  logic          err_o;
  logic [RW-1:0] first_ret_pkt_o;

  logic          in_fwd_v, in_rev_v, in_rev_rdy;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_pay;
  logic [RW-1:0] in_ret, in_rev_data;

  assign link_sif_i = {in_fwd_v, in_addr, in_pay, in_ret, 1'b0, in_rev_v, in_rev_data, in_rev_rdy};

  logic           o_fwd_v, o_fwd_rdy, o_rev_v, o_rev_rdy;
  logic [FPW-1:0] o_fwd_data;
  logic [RW-1:0]  o_rev_data;
  assign o_fwd_v    = link_sif_o[LW-1];
  assign o_fwd_data = link_sif_o[LW-2 -: FPW];
  assign o_fwd_rdy  = link_sif_o[REVW];
  assign o_rev_v    = link_sif_o[REVW-1];
  assign o_rev_data = link_sif_o[REVW-2 -: RW];
  assign o_rev_rdy  = link_sif_o[0];

  bsg_manycore_link_sif_edge_absorber #(
    .addr_width_p(AW), .data_width_p(DW), .x_cord_width_p(XW), .y_cord_width_p(YW),
    .fifo_els_p(ELS), .count_width_p(CW)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .link_sif_i(link_sif_i), .link_sif_o(link_sif_o),
    .fwd_count_o(fwd_count_o), .rev_drop_count_o(rev_drop_count_o),
    .err_o(err_o), .first_ret_pkt_o(first_ret_pkt_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: expected FIFO contents, occupancy and counter values.
  logic [RW-1:0] exp_q[$];
  int            occ = 0;
  int            m_fwd = 0, m_drop = 0;
  bit            m_err = 0;
  logic [RW-1:0] m_first = '0;

  // Monitor: every credit the DUT hands over must match the oldest accepted packet.
  initial forever begin
    @(negedge clk); #2;
    if (!reset_i && o_rev_v && in_rev_rdy) begin
      if (exp_q.size() == 0) chk("credit_unexpected", 64'(o_rev_v), 64'd0);
      else                   chk("credit_data", 64'(o_rev_data), 64'(exp_q.pop_front()));
    end
  end

  // Predictor: checks handshake/status outputs, then applies this cycle's events to the model.
  initial forever begin
    bit acc, deq;
    @(negedge clk); #3;
    if (reset_i) begin
      chk("rst_fwd_ready", 64'(o_fwd_rdy), 64'd0);
      chk("rst_rev_v", 64'(o_rev_v), 64'd0);
      chk("rst_fwd_count", 64'(fwd_count_o), 64'd0);
      chk("rst_drop_count", 64'(rev_drop_count_o), 64'd0);
      chk("rst_err", 64'(err_o), 64'd0);
      chk("rst_first", 64'(first_ret_pkt_o), 64'd0);
      exp_q.delete();
      occ = 0; m_fwd = 0; m_drop = 0; m_err = 0; m_first = '0;
    end else begin
      chk("fwd_ready", 64'(o_fwd_rdy), 64'(occ < ELS));
      chk("rev_v", 64'(o_rev_v), 64'(occ > 0));
      chk("rev_ready_out", 64'(o_rev_rdy), 64'd1);
      chk("fwd_static", 64'({o_fwd_v, |o_fwd_data}), 64'd0);
      chk("fwd_count", 64'(fwd_count_o), 64'(m_fwd));
      chk("drop_count", 64'(rev_drop_count_o), 64'(m_drop));
      chk("err", 64'(err_o), 64'(m_err));
      chk("first_ret", 64'(first_ret_pkt_o), 64'(m_first));
      acc = in_fwd_v && (occ < ELS);
      deq = (occ > 0) && in_rev_rdy;
      if (acc) begin
        exp_q.push_back(in_ret);
        if (!m_err) begin m_err = 1; m_first = in_ret; end
        if (m_fwd < MAXC) m_fwd++;
      end
      if (in_rev_v && m_drop < MAXC) m_drop++;
      occ = occ + int'(acc) - int'(deq);
    end
  end

  task automatic randomize_inputs(input int pf, input int pr, input int ps);
    in_fwd_v    = ($urandom_range(99) < pf);
    in_rev_rdy  = ($urandom_range(99) < pr);
    in_rev_v    = ($urandom_range(99) < ps);
    in_addr     = AW'($urandom);
    in_pay      = DW'($urandom);
    in_ret      = RW'($urandom);
    in_rev_data = RW'($urandom);
  endtask

  initial begin
    int pf, pr, ps;
    reset_i = 1'b1;
    randomize_inputs(100, 50, 50);
    in_fwd_v = 1'b1;
    repeat (4) begin
      @(negedge clk);
      in_fwd_v = 1'b1;
    end
    @(negedge clk);
    reset_i = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      case ((cyc / 250) % 4)
        0: begin pf = 80; pr = 5;  ps = 10; end
        1: begin pf = 50; pr = 90; ps = 50; end
        2: begin pf = 95; pr = 40; ps = 0;  end
        default: begin pf = 10; pr = 70; ps = 90; end
      endcase
      randomize_inputs(pf, pr, ps);
      // Occasional resets, including ones that land with entries still queued.
      reset_i = (($urandom_range(299) == 0) || (cyc % 1000 == 999));
      @(negedge clk);
    end
    reset_i = 1'b0;
    in_fwd_v = 1'b0; in_rev_v = 1'b0; in_rev_rdy = 1'b1;
    repeat (ELS + 3) @(negedge clk);
    #4;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
